// File: rtl/filter_peak_finder.sv
// Threshold-crossing pulse detector: peak amplitude, peak timestamp and width per pulse,
// one-deep event register with dead-time holdoff. Optional area sum: FILTER_PEAK_FINDER_AREA_EN.
module filter_peak_finder #(
  parameter int DATA_W    = 16,
  parameter int TIME_W    = 16,
  parameter int WIDTH_W   = 8,
  parameter int MIN_WIDTH = 2,
  parameter int HOLDOFF   = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_W-1:0]           input_data,
  input  logic [DATA_W-1:0]           threshold,
  input  logic                        event_ready,
  output logic                        event_valid,
  output logic [DATA_W-1:0]           event_amplitude,
  output logic [TIME_W-1:0]           event_time,
  output logic [WIDTH_W-1:0]          event_width,
  output logic                        event_truncated,
  output logic [DATA_W+WIDTH_W-1:0]   event_area,
  output logic [7:0]                  lost_count
);

  // state    | meaning
  // ST_IDLE  | waiting for a sample above threshold
  // ST_PULSE | inside a pulse, tracking max/width
  // ST_HOLD  | dead time after a pulse, input ignored
  typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_HOLD} state_t;

  localparam int                 AREA_W    = DATA_W + WIDTH_W;
  localparam int                 HOLD_INIT = (HOLDOFF > 0) ? HOLDOFF - 1 : 0;
  localparam logic [7:0]         HOLD_LOAD = HOLD_INIT[7:0];
  localparam logic [WIDTH_W-1:0] WIDTH_MAX = '1;
  localparam logic [WIDTH_W-1:0] MIN_W     = WIDTH_W'(MIN_WIDTH);

  state_t               state_q, state_d;
  logic [TIME_W-1:0]    ts_q, ts_d;
  logic [DATA_W-1:0]    max_q, max_d;
  logic [TIME_W-1:0]    max_time_q, max_time_d;
  logic [WIDTH_W-1:0]   width_q, width_d;
  logic [7:0]           hold_q, hold_d;
  logic                 ev_valid_q, ev_valid_d;
  logic [DATA_W-1:0]    ev_amp_q, ev_amp_d;
  logic [TIME_W-1:0]    ev_time_q, ev_time_d;
  logic [WIDTH_W-1:0]   ev_width_q, ev_width_d;
  logic                 ev_trunc_q, ev_trunc_d;
  logic [7:0]           lost_q, lost_d;
  logic                 crossing, pulse_end, end_trunc;

`ifdef FILTER_PEAK_FINDER_AREA_EN
  logic [AREA_W-1:0]    area_q, area_d;
  logic [AREA_W-1:0]    ev_area_q, ev_area_d;
  logic [AREA_W-1:0]    sample_ext;
  assign sample_ext = {{WIDTH_W{input_data[DATA_W-1]}}, input_data};
`endif

  assign crossing = $signed(input_data) > $signed(threshold);

  always_comb begin
    state_d    = state_q;
    ts_d       = ts_q + 1'b1;
    max_d      = max_q;
    max_time_d = max_time_q;
    width_d    = width_q;
    hold_d     = hold_q;
    ev_valid_d = ev_valid_q;
    ev_amp_d   = ev_amp_q;
    ev_time_d  = ev_time_q;
    ev_width_d = ev_width_q;
    ev_trunc_d = ev_trunc_q;
    lost_d     = lost_q;
    pulse_end  = 1'b0;
    end_trunc  = 1'b0;
`ifdef FILTER_PEAK_FINDER_AREA_EN
    area_d     = area_q;
    ev_area_d  = ev_area_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (crossing) begin
          state_d    = ST_PULSE;
          max_d      = input_data;
          max_time_d = ts_q;
          width_d    = {{(WIDTH_W-1){1'b0}}, 1'b1};
`ifdef FILTER_PEAK_FINDER_AREA_EN
          area_d     = sample_ext;
`endif
        end
      end
      ST_PULSE: begin
        if (crossing) begin
          width_d = width_q + 1'b1;
          if ($signed(input_data) > $signed(max_q)) begin
            max_d      = input_data;
            max_time_d = ts_q;
          end
`ifdef FILTER_PEAK_FINDER_AREA_EN
          area_d = area_q + sample_ext;
`endif
          if (width_d == WIDTH_MAX) begin
            pulse_end = 1'b1;
            end_trunc = 1'b1;
          end
        end else begin
          pulse_end = 1'b1;
        end
      end
      ST_HOLD: begin
        if (hold_q == 8'd0) state_d = ST_IDLE;
        else                hold_d  = hold_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (ev_valid_q && event_ready) ev_valid_d = 1'b0;

    if (pulse_end) begin
      state_d = (HOLDOFF == 0) ? ST_IDLE : ST_HOLD;
      hold_d  = HOLD_LOAD;
      // The *_d values already include the final in-pulse sample (truncation case).
      if (width_d >= MIN_W) begin
        if (!ev_valid_q || event_ready) begin
          ev_valid_d = 1'b1;
          ev_amp_d   = max_d;
          ev_time_d  = max_time_d;
          ev_width_d = width_d;
          ev_trunc_d = end_trunc;
`ifdef FILTER_PEAK_FINDER_AREA_EN
          ev_area_d  = area_d;
`endif
        end else if (lost_q != 8'hFF) begin
          lost_d = lost_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      ts_q       <= '0;
      max_q      <= '0;
      max_time_q <= '0;
      width_q    <= '0;
      hold_q     <= '0;
      ev_valid_q <= 1'b0;
      ev_amp_q   <= '0;
      ev_time_q  <= '0;
      ev_width_q <= '0;
      ev_trunc_q <= 1'b0;
      lost_q     <= '0;
`ifdef FILTER_PEAK_FINDER_AREA_EN
      area_q     <= '0;
      ev_area_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ts_q       <= ts_d;
      max_q      <= max_d;
      max_time_q <= max_time_d;
      width_q    <= width_d;
      hold_q     <= hold_d;
      ev_valid_q <= ev_valid_d;
      ev_amp_q   <= ev_amp_d;
      ev_time_q  <= ev_time_d;
      ev_width_q <= ev_width_d;
      ev_trunc_q <= ev_trunc_d;
      lost_q     <= lost_d;
`ifdef FILTER_PEAK_FINDER_AREA_EN
      area_q     <= area_d;
      ev_area_q  <= ev_area_d;
`endif
    end
  end

  assign event_valid     = ev_valid_q;
  assign event_amplitude = ev_amp_q;
  assign event_time      = ev_time_q;
  assign event_width     = ev_width_q;
  assign event_truncated = ev_trunc_q;
  assign lost_count      = lost_q;
`ifdef FILTER_PEAK_FINDER_AREA_EN
  assign event_area      = ev_area_q;
`else
  assign event_area      = '0;
`endif

endmodule

// File: tb/tb_filter_peak_finder.sv
// Bench for filter_peak_finder: directed scenarios plus random bursts against a queue-based pulse model.
module tb_filter_peak_finder;
  localparam int DATA_W = 16, TIME_W = 16, WIDTH_W = 8, MIN_WIDTH = 2, HOLDOFF = 8;
  localparam int VW = 1 + DATA_W + TIME_W + WIDTH_W + 1 + DATA_W + WIDTH_W + 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [DATA_W-1:0] input_data = '0, threshold = '0;
  logic event_ready = 1'b0;
  logic event_valid, event_truncated;
  logic [DATA_W-1:0] event_amplitude;
  logic [TIME_W-1:0] event_time;
  logic [WIDTH_W-1:0] event_width;
  logic [DATA_W+WIDTH_W-1:0] event_area;
  logic [7:0] lost_count;

  int n_cmp = 0, n_fail = 0;

  always #5 clk = ~clk;

  filter_peak_finder #(.DATA_W(DATA_W), .TIME_W(TIME_W), .WIDTH_W(WIDTH_W),
                       .MIN_WIDTH(MIN_WIDTH), .HOLDOFF(HOLDOFF)) dut (
    .clk(clk), .reset(reset), .input_data(input_data), .threshold(threshold),
    .event_ready(event_ready), .event_valid(event_valid), .event_amplitude(event_amplitude),
    .event_time(event_time), .event_width(event_width), .event_truncated(event_truncated),
    .event_area(event_area), .lost_count(lost_count));

  // Reference model: a pulse is collected as a list of samples; its event is derived at the end.
  int m_ts, m_mode, m_dead;   // mode 0 idle, 1 in pulse, 2 dead time
  int pq[$];
  int pts[$];
  bit m_valid, m_trunc;
  int m_amp, m_time, m_width, m_area, m_lost;

  task automatic model_reset();
    m_ts = 0; m_mode = 0; m_dead = 0; pq.delete(); pts.delete();
    m_valid = 0; m_trunc = 0; m_amp = 0; m_time = 0; m_width = 0; m_area = 0; m_lost = 0;
  endtask

  task automatic model_edge(input int d, input int t, input bit r);
    bit fin, trunc, loaded, xfer;
    int bi, sum;
    fin = 0; trunc = 0; loaded = 0; xfer = m_valid && r;
    case (m_mode)
      0: if (d > t) begin pq = {d}; pts = {m_ts}; m_mode = 1; end
      1: begin
        if (d > t) begin
          pq.push_back(d); pts.push_back(m_ts);
          if (pq.size() == (1 << WIDTH_W) - 1) begin fin = 1; trunc = 1; end
        end else fin = 1;
      end
      default: begin m_dead--; if (m_dead == 0) m_mode = 0; end
    endcase
    if (fin) begin
      if (pq.size() >= MIN_WIDTH) begin
        bi = 0; sum = 0;
        foreach (pq[i]) begin
          if (pq[i] > pq[bi]) bi = i;
          sum += pq[i];
        end
        if (!m_valid || r) begin
          loaded = 1; m_amp = pq[bi]; m_time = pts[bi]; m_width = pq.size();
          m_trunc = trunc; m_area = sum;
        end else if (m_lost < 255) m_lost++;
      end
      pq.delete(); pts.delete();
      if (HOLDOFF == 0) m_mode = 0;
      else begin m_mode = 2; m_dead = HOLDOFF; end
    end
    if (loaded) m_valid = 1;
    else if (xfer) m_valid = 0;
    m_ts = (m_ts + 1) % (1 << TIME_W);
  endtask

  function automatic logic [VW-1:0] exp_vec();
    logic [DATA_W+WIDTH_W-1:0] a;
`ifdef FILTER_PEAK_FINDER_AREA_EN
    a = m_area[DATA_W+WIDTH_W-1:0];
`else
    a = '0;
`endif
    return {m_valid, m_amp[DATA_W-1:0], m_time[TIME_W-1:0], m_width[WIDTH_W-1:0],
            m_trunc, a, m_lost[7:0]};
  endfunction

  function automatic logic [VW-1:0] act_vec();
    return {event_valid, event_amplitude, event_time, event_width, event_truncated,
            event_area, lost_count};
  endfunction

  // Drives one sample for one clock; outputs are stable at the following negedge.
  task automatic cycle(input int d, input int t, input bit r);
    input_data = d[DATA_W-1:0]; threshold = t[DATA_W-1:0]; event_ready = r;
    @(posedge clk);
    model_edge(d, t, r);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (act_vec() !== '0) begin
      n_fail++; $display("FAIL reset_state got=%h want=0", act_vec());
    end
    reset = 1'b1;
  endtask

  task automatic test_basic();
    int seq[8] = '{0, 0, 0, 0, 150, 300, 250, 80};
    foreach (seq[i]) begin
      cycle(seq[i], 100, 1);
      n_cmp++;
      if (act_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL basic i=%0d got=%h want=%h", i, act_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (event_valid !== 1'b1 || event_amplitude !== 16'd300 || event_time !== 16'd5 ||
        event_width !== 8'd3 || event_truncated !== 1'b0) begin
      n_fail++; $display("FAIL basic_event got v=%b amp=%0d t=%0d w=%0d tr=%b want 1/300/5/3/0",
                         event_valid, event_amplitude, event_time, event_width, event_truncated);
    end
`ifdef FILTER_PEAK_FINDER_AREA_EN
    n_cmp++;
    if (event_area !== 24'd700) begin
      n_fail++; $display("FAIL basic_area got=%0d want=700", event_area);
    end
`endif
    cycle(0, 100, 1);
    n_cmp++;
    if (event_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_valid_one_clk got=%b want=0", event_valid);
    end
  endtask

  task automatic test_short_and_ties();
    int t0;
    repeat (10) cycle(0, 100, 1);
    cycle(200, 100, 1);
    cycle(0, 100, 1);
    repeat (2) cycle(0, 100, 1);
    n_cmp++;
    if (event_valid !== 1'b0 || lost_count !== 8'd0 || act_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL short_pulse got v=%b lost=%0d want v=0 lost=0", event_valid, lost_count);
    end
    repeat (10) cycle(0, 100, 1);
    t0 = m_ts;
    cycle(300, 100, 1);
    cycle(300, 100, 1);
    cycle(100, 100, 1);
    n_cmp++;
    if (event_valid !== 1'b1 || event_time !== t0[TIME_W-1:0] || event_width !== 8'd2 ||
        event_amplitude !== 16'd300) begin
      n_fail++; $display("FAIL tie_first got v=%b t=%0d w=%0d want 1 t=%0d w=2",
                         event_valid, event_time, event_width, t0);
    end
    n_cmp++;
    if (act_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL tie_model got=%h want=%h", act_vec(), exp_vec());
    end
    repeat (10) cycle(0, 100, 1);
  endtask

  task automatic test_backpressure();
    int t_first;
    for (int p = 0; p < 3; p++) begin
      if (p == 0) t_first = m_ts + 1;
      cycle(150, 100, 0); cycle(200, 100, 0); cycle(0, 100, 0);
      repeat (12) begin
        cycle(0, 100, 0);
        n_cmp++;
        if (act_vec() !== exp_vec()) begin
          n_fail++; $display("FAIL backpressure p=%0d got=%h want=%h", p, act_vec(), exp_vec());
        end
      end
    end
    n_cmp++;
    if (event_valid !== 1'b1 || lost_count !== 8'd2 || event_amplitude !== 16'd200 ||
        event_time !== t_first[TIME_W-1:0]) begin
      n_fail++; $display("FAIL hold_first got v=%b lost=%0d amp=%0d t=%0d want 1/2/200/%0d",
                         event_valid, lost_count, event_amplitude, event_time, t_first);
    end
    cycle(0, 100, 1);
    n_cmp++;
    if (event_valid !== 1'b0 || event_amplitude !== 16'd200 || event_time !== t_first[TIME_W-1:0]) begin
      n_fail++; $display("FAIL drain got v=%b amp=%0d t=%0d want 0/200/%0d",
                         event_valid, event_amplitude, event_time, t_first);
    end
    repeat (3) cycle(0, 100, 1);
  endtask

  task automatic test_truncation();
    repeat (10) cycle(0, 100, 1);
    for (int i = 0; i < 300; i++) begin
      cycle(500, 100, 1);
      n_cmp++;
      if (act_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL trunc i=%0d got=%h want=%h", i, act_vec(), exp_vec());
      end
      if (i == 254) begin
        n_cmp++;
        if (event_valid !== 1'b1 || event_width !== 8'd255 || event_truncated !== 1'b1) begin
          n_fail++; $display("FAIL trunc_event got v=%b w=%0d tr=%b want 1/255/1",
                             event_valid, event_width, event_truncated);
        end
      end
    end
    cycle(0, 100, 1);
    n_cmp++;
    if (event_valid !== 1'b1 || event_width !== 8'd37 || event_truncated !== 1'b0) begin
      n_fail++; $display("FAIL after_holdoff got v=%b w=%0d tr=%b want 1/37/0",
                         event_valid, event_width, event_truncated);
    end
    repeat (10) cycle(0, 100, 1);
  endtask

  task automatic test_reset_midpulse();
    int seq[5] = '{0, 150, 300, 250, 80};
    cycle(150, 100, 0); cycle(200, 100, 0); cycle(0, 100, 0);
    repeat (10) cycle(0, 100, 0);
    cycle(300, 100, 0); cycle(300, 100, 0);
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if (act_vec() !== '0) begin
      n_fail++; $display("FAIL async_reset got=%h want=0", act_vec());
    end
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    foreach (seq[i]) begin
      cycle(seq[i], 100, 1);
      n_cmp++;
      if (act_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL post_reset i=%0d got=%h want=%h", i, act_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (event_valid !== 1'b1 || event_time !== 16'd2 || event_amplitude !== 16'd300 ||
        lost_count !== 8'd0) begin
      n_fail++; $display("FAIL post_reset_event got v=%b t=%0d amp=%0d lost=%0d want 1/2/300/0",
                         event_valid, event_time, event_amplitude, lost_count);
    end
    repeat (10) cycle(0, 100, 1);
  endtask

  task automatic test_random();
    bit hi;
    int thr, d;
    bit r;
    hi = 0; thr = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) thr = int'($urandom_range(400)) - 200;
      if ($urandom_range(7) == 0) hi = !hi;
      if (hi) d = thr + 1 + 50 * int'($urandom_range(3));
      else    d = thr - int'($urandom_range(100));
      r = ($urandom_range(3) != 0);
      cycle(d, thr, r);
      n_cmp++;
      if (act_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random i=%0d got=%h want=%h", i, act_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_short_and_ties();
    test_backpressure();
    test_truncation();
    test_reset_midpulse();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
